// File: rtl/ttm4_isa_pkg.sv
// Shared ISA definitions for the TTM4 instruction encoder: mnemonic codes,
// opcode constants, register codes and instruction word geometry.
package ttm4_isa_pkg;

  localparam int unsigned OP_W    = 5;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned WORD_W  = OP_W + 2 * REG_W;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned COUNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    MNEM_NOP  = 3'd0,
    MNEM_XOR  = 3'd1,
    MNEM_AND  = 3'd2,
    MNEM_OR   = 3'd3,
    MNEM_ADD  = 3'd4,
    MNEM_SKZ  = 3'd5,
    MNEM_SKC  = 3'd6,
    MNEM_RSVD = 3'd7
  } mnemT;

  localparam logic [OP_W-1:0] OP_NOP = 5'b00000;
  localparam logic [OP_W-1:0] OP_XOR = 5'b00001;
  localparam logic [OP_W-1:0] OP_AND = 5'b10000;
  localparam logic [OP_W-1:0] OP_OR  = 5'b10010;
  localparam logic [OP_W-1:0] OP_ADD = 5'b10100;
  localparam logic [OP_W-1:0] OP_SKZ = 5'b01000;
  localparam logic [OP_W-1:0] OP_SKC = 5'b01001;

  // Source codes
  localparam logic [REG_W-1:0] SRC_A   = 3'd2;
  localparam logic [REG_W-1:0] SRC_B   = 3'd3;
  localparam logic [REG_W-1:0] SRC_IRU = 3'd4;
  localparam logic [REG_W-1:0] SRC_IRD = 3'd5;
  localparam logic [REG_W-1:0] SRC_JRU = 3'd6;
  localparam logic [REG_W-1:0] SRC_JRD = 3'd7;
  // Destination codes
  localparam logic [REG_W-1:0] DST_A   = 3'd2;
  localparam logic [REG_W-1:0] DST_B   = 3'd3;
  localparam logic [REG_W-1:0] DST_ORU = 3'd4;
  localparam logic [REG_W-1:0] DST_ORD = 3'd5;
  localparam logic [REG_W-1:0] DST_JRU = 3'd6;
  localparam logic [REG_W-1:0] DST_JRD = 3'd7;

  localparam logic [REG_W-1:0] REG_MIN_LEGAL = 3'd2;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_MNEM = 2'd1,
    ERR_SRC  = 2'd2,
    ERR_DST  = 2'd3
  } errCodeT;

  function automatic logic [WORD_W-1:0] packWord(input logic [OP_W-1:0]  op,
                                                 input logic [REG_W-1:0] lr,
                                                 input logic [REG_W-1:0] sr);
    return {op, lr, sr};
  endfunction

endpackage

// File: rtl/op_lookup.sv
// Combinational mnemonic-to-word translation with legality checking.
// Error priority: reserved mnemonic, then source, then destination.
module op_lookup
  import ttm4_isa_pkg::*;
(
  input  logic [2:0]        mnem,
  input  logic [REG_W-1:0]  src,
  input  logic [REG_W-1:0]  dst,
  output logic [WORD_W-1:0] word,
  output logic              legal,
  output logic [1:0]        errCode
);

  logic [OP_W-1:0] op;
  logic            useSrc;
  logic            useDst;
  logic            known;

  always_comb begin
    op     = OP_NOP;
    useSrc = 1'b0;
    useDst = 1'b0;
    known  = 1'b1;
    case (mnemT'(mnem))
      MNEM_NOP: op = OP_NOP;
      MNEM_XOR: begin op = OP_XOR; useSrc = 1'b1; useDst = 1'b1; end
      MNEM_AND: begin op = OP_AND; useSrc = 1'b1; useDst = 1'b1; end
      MNEM_OR:  begin op = OP_OR;  useSrc = 1'b1; useDst = 1'b1; end
      MNEM_ADD: begin op = OP_ADD; useSrc = 1'b1; useDst = 1'b1; end
      MNEM_SKZ: begin op = OP_SKZ; useSrc = 1'b1; end
      MNEM_SKC: begin op = OP_SKC; useSrc = 1'b1; end
      default:  known = 1'b0;
    endcase

    legal   = 1'b1;
    errCode = ERR_NONE;
    if (!known) begin
      legal   = 1'b0;
      errCode = ERR_MNEM;
    end else if (useSrc && (src < REG_MIN_LEGAL)) begin
      legal   = 1'b0;
      errCode = ERR_SRC;
    end else if (useDst && (dst < REG_MIN_LEGAL)) begin
      legal   = 1'b0;
      errCode = ERR_DST;
    end

    // Unused fields are zeroed so that the stored word does not depend on them.
    word = packWord(op, useSrc ? src : '0, useDst ? dst : '0);
  end

endmodule

// File: rtl/instruction_encoder.sv
// Mnemonic request -> program-memory writer: captures a request, checks it,
// then holds a write until acknowledged, tracking address, count and errors.
module instruction_encoder
  import ttm4_isa_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [2:0]         MNEM,
  input  logic [REG_W-1:0]   SRC,
  input  logic [REG_W-1:0]   DST,
  input  logic               CLR,
  output logic               WR_EN,
  output logic [ADDR_W-1:0]  WR_ADDR,
  output logic [WORD_W-1:0]  WR_DATA,
  input  logic               WR_ACK,
  output logic               ERR,
  output logic [1:0]         ERR_CODE,
  output logic               FULL,
  output logic [COUNT_W-1:0] COUNT
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE, S_FULL} stateT;

  stateT               state;
  stateT               stateNext;
  logic                armed;
  logic [2:0]          mnemQ;
  logic [REG_W-1:0]    srcQ;
  logic [REG_W-1:0]    dstQ;
  logic [WORD_W-1:0]   wordQ;
  logic [ADDR_W-1:0]   addrQ;
  logic [COUNT_W-1:0]  countQ;
  logic                errQ;
  logic [1:0]          errCodeQ;
  logic [WORD_W-1:0]   lookupWord;
  logic                lookupLegal;
  logic [1:0]          lookupErrCode;
  logic                accept;
  logic                ackTaken;

  op_lookup uLookup (
    .mnem    (mnemQ),
    .src     (srcQ),
    .dst     (dstQ),
    .word    (lookupWord),
    .legal   (lookupLegal),
    .errCode (lookupErrCode)
  );

  // armed holds IN_READY low until the first clock edge after reset release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      armed <= 1'b0;
    end else begin
      state <= stateNext;
      armed <= 1'b1;
    end
  end

  always_comb begin
    IN_READY  = (state == S_IDLE) && armed;
    WR_EN     = (state == S_WRITE);
    FULL      = (state == S_FULL);
    accept    = IN_VALID && IN_READY && !CLR;
    ackTaken  = WR_EN && WR_ACK && !CLR;
    stateNext = state;
    case (state)
      S_IDLE:  if (accept) stateNext = S_CHECK;
      S_CHECK: stateNext = lookupLegal ? S_WRITE : S_IDLE;
      S_WRITE: if (ackTaken) stateNext = (addrQ == '1) ? S_FULL : S_IDLE;
      S_FULL:  stateNext = S_FULL;
      default: stateNext = S_IDLE;
    endcase
    if (CLR) stateNext = S_IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mnemQ    <= '0;
      srcQ     <= '0;
      dstQ     <= '0;
      wordQ    <= '0;
      addrQ    <= '0;
      countQ   <= '0;
      errQ     <= 1'b0;
      errCodeQ <= '0;
    end else if (CLR) begin
      addrQ    <= '0;
      countQ   <= '0;
      errQ     <= 1'b0;
      errCodeQ <= '0;
    end else begin
      if (accept) begin
        mnemQ <= MNEM;
        srcQ  <= SRC;
        dstQ  <= DST;
      end
      if (state == S_CHECK) begin
        if (lookupLegal) begin
          wordQ <= lookupWord;
        end else begin
          errQ     <= 1'b1;
          errCodeQ <= lookupErrCode;
        end
      end
      if (ackTaken) begin
        addrQ  <= addrQ + ADDR_W'(1);
        countQ <= countQ + COUNT_W'(1);
      end
    end
  end

  assign WR_ADDR  = addrQ;
  assign WR_DATA  = wordQ;
  assign COUNT    = countQ;
  assign ERR      = errQ;
  assign ERR_CODE = errCodeQ;

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: RST  in  1  reset; asynchronous, active-high.
REQ-003 SHALL have ports: IN_VALID  in  1  mnemonic request present.
REQ-004 SHALL have ports: IN_READY  out  1  encoder accepts request this cycle.
REQ-005 SHALL have ports: MNEM  in  3  0 NOP, 1 XOR, 2 AND, 3 OR, 4 ADD, 5 SKZ, 6 SKC, 7 reserved.
REQ-006 SHALL have ports: SRC  in  3  source register code (2 A, 3 B, 4 IRU, 5 IRD, 6 JRU, 7 JRD).
REQ-007 SHALL have ports: DST  in  3  destination code (2 A, 3 B, 4 ORU, 5 ORD, 6 JRU, 7 JRD).
REQ-008 SHALL have ports: CLR  in  1  synchronous restart of address, count, flags.
REQ-009 SHALL have ports: WR_EN  out  1  program-memory write request.
REQ-010 SHALL have ports: WR_ADDR  out  8  write address.
REQ-011 SHALL have ports: WR_DATA  out  11  instruction word {OP[4:0], LR[2:0], SR[2:0]}.
REQ-012 SHALL have ports: WR_ACK  in  1  memory accepted the write.
REQ-013 SHALL have ports: ERR  out  1  sticky illegal-request flag.
REQ-014 SHALL have ports: ERR_CODE  out  2  last error: 1 reserved MNEM, 2 bad SRC, 3 bad DST.
REQ-015 SHALL have ports: FULL  out  1  256 words written.
REQ-016 SHALL have ports: COUNT  out  9  words written, 0..256.

Function
REQ-017 SHALL map MNEM to OP: NOP 00000, XOR 00001, AND 10000, OR 10010, ADD 10100, SKZ 01000, SKC 01001.
REQ-018 SHALL force LR=SR=000 for NOP, SR=000 for SKZ/SKC; other mnemonics use LR=SRC, SR=DST.
REQ-019 SHALL treat SRC<2 or DST<2 as illegal where the field is used; priority MNEM > SRC > DST.
REQ-020 SHALL implement FSM IDLE, CHECK, WRITE, FULL; IN_READY=1 only in IDLE and not RST.
REQ-021 SHALL capture MNEM/SRC/DST on IN_VALID&IN_READY at cycle N and enter CHECK at N+1.
REQ-022 SHALL in CHECK: illegal -> set ERR, load ERR_CODE, return IDLE, no write; legal -> WRITE at N+2.
REQ-023 SHALL hold WR_EN=1 with WR_ADDR/WR_DATA stable throughout WRITE until WR_ACK sampled high.
REQ-024 SHALL accept WR_ACK in the first WRITE cycle; on ACK increment address (mod 256) and COUNT.
REQ-025 SHALL on ACK at address 255 enter FULL: FULL=1, COUNT=256, IN_READY=0 until CLR or RST.
REQ-026 SHALL ignore WR_ACK outside WRITE.
REQ-027 SHALL on CLR in any state go to IDLE next cycle, address=0, COUNT=0, FULL=0, ERR=0, ERR_CODE=0; a pending write is abandoned (WR_EN=0).
REQ-028 SHALL give CLR priority over a simultaneous IN_VALID or WR_ACK (neither takes effect).
REQ-029 SHALL keep ERR sticky across later legal writes; a new error overwrites ERR_CODE.

Reset
REQ-030 SHALL while RST=1 force state IDLE, IN_READY=0, WR_EN=0, WR_ADDR=0, WR_DATA=0, ERR=0, ERR_CODE=0, FULL=0, COUNT=0.
REQ-031 SHALL on RST mid-WRITE drop WR_EN asynchronously; no address increment.
REQ-032 SHALL assert IN_READY on the first rising edge after RST deasserts.

Structure
REQ-033 SHALL place MNEM codes, OP constants, register codes and word field widths in shared package ttm4_isa_pkg.
REQ-034 SHALL place MNEM->OP lookup and legality check in combinational sub-module op_lookup; FSM and counters stay in the top.

Verification
REQ-035 SHALL test ADD SRC=2 DST=3, ACK at first WRITE cycle -> WR_EN at N+2, WR_ADDR=0, WR_DATA=10100_010_011, COUNT=1.
REQ-036 SHALL test MNEM=7 -> no WR_EN, ERR=1, ERR_CODE=1, IN_READY back at N+2; then legal OR B->JRU writes 10010_011_110 at addr 0.
REQ-037 SHALL test ACK delayed 5 cycles -> WR_EN/WR_ADDR/WR_DATA stable 5+1 cycles, IN_READY=0 throughout.
REQ-038 SHALL test 256 legal writes -> FULL=1, COUNT=256, IN_READY=0; CLR -> FULL=0, COUNT=0, next write addr 0.
REQ-039 SHALL test CLR and WR_ACK same cycle in WRITE at addr 9 -> WR_EN=0 next cycle, COUNT=0, address 0.
REQ-040 SHALL test RST pulse during WRITE -> WR_EN=0 immediately, all outputs at reset values, IN_READY=1 after first post-reset edge.
